peripheral_dsa_modular_adder_arbiter: RTL
=========================================

Name: peripheral_dsa_modular_adder_arbiter

Overview:
Round-robin scheduler that shares one modular adder/subtractor between N_REQ requesters.
- Accepts one request at a time, latches its operands and starts the adder.
- Waits for the adder's READY, then returns the result to the granted requester.
- Sits between the DSA requesters (e.g. NTM vector engines) and the single modular adder instance.

Parameters:
DATA_SIZE, 64, operand/result width (matches the adder datapath)
N_REQ, 4, number of requesters (>=1)
ID_WIDTH, $clog2(N_REQ) (1 when N_REQ==1), width of GRANT_ID

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  asynchronous, active-low reset
REQ_VALID  in  N_REQ  per-requester request pending
REQ_OPERATION  in  N_REQ  per-requester op: 0=add, 1=subtract
REQ_MODULO  in  N_REQ*DATA_SIZE  flattened moduli, requester i at [i*DATA_SIZE +: DATA_SIZE]
REQ_DATA_A  in  N_REQ*DATA_SIZE  flattened operand A
REQ_DATA_B  in  N_REQ*DATA_SIZE  flattened operand B
REQ_READY  out  N_REQ  one-hot one-cycle accept pulse
RSP_VALID  out  N_REQ  one-hot one-cycle result pulse
RSP_DATA  out  DATA_SIZE  result, valid while RSP_VALID, held until next result
ADDER_START  out  1  one-cycle start pulse to adder
ADDER_OPERATION  out  1  op to adder
ADDER_MODULO / ADDER_DATA_A / ADDER_DATA_B  out  DATA_SIZE each  adder operands
ADDER_READY  in  1  adder completion
ADDER_DATA_OUT  in  DATA_SIZE  adder result
BUSY  out  1  high in any state except IDLE
GRANT_ID  out  ID_WIDTH  index of the current or last grant

Behaviour:
- Reset (RST=0, asynchronous):
  - Every output goes to 0, state goes to IDLE.
  - Round-robin pointer last_grant resets to N_REQ-1, so requester 0 has first priority.
  - Reset mid-operation abandons the transaction: no RSP_VALID, adder outputs drop to 0.
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - If any REQ_VALID bit is set, select g = first set bit searching (last_grant+1) mod N_REQ upward with wrap.
  - Latch REQ_OPERATION[g], MODULO, A, B into ADDER_* registers; set GRANT_ID=g.
  - Pulse REQ_READY[g] for this cycle only; go to ISSUE.
  - With no REQ_VALID set, stay in IDLE.
- ISSUE: ADDER_START=1 for exactly one cycle; go to WAIT. ADDER_READY sampled in ISSUE is ignored.
- WAIT:
  - ADDER_* operands stay stable.
  - On ADDER_READY=1, register ADDER_DATA_OUT into RSP_DATA and go to RESPOND.
  - No timeout: stays in WAIT indefinitely.
- RESPOND: RSP_VALID[g]=1 for one cycle; last_grant<=g; go to IDLE.
- Latency: request accepted at edge k.
  - ADDER_START is high in cycle k+1.
  - RSP_VALID is high one cycle after ADDER_READY is sampled.
  - Minimum occupancy is 4 cycles plus adder latency.
- Requester rules:
  - Operands are sampled only in the REQ_READY cycle and may change afterwards.
  - REQ_VALID may drop before grant; no grant is issued.
  - REQ_VALID still high after RESPOND is treated as a new request and arbitrated normally.
- Fairness: a requester waits at most N_REQ-1 transactions. Simultaneous requests are ordered strictly by rotation.
- MODULO=0 and operands >= MODULO are passed through unchecked; result correctness is the adder's responsibility.
- N_REQ=1: the arbiter degenerates to a sequencer; GRANT_ID stays 0.

Decomposition:
- Package peripheral_dsa_pkg holds:
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} arbiter_state_t;
  - OP_ADD=1'b0 and OP_SUB=1'b1 constants.
- Sub-module peripheral_dsa_rr_arbiter: combinational N_REQ-wide round-robin picker.
  - Inputs: request vector, last_grant.
  - Outputs: one-hot grant, grant index, any_req.

Test Plan:
1. Reset then REQ_VALID[0], op=0, M=13, A=9, B=7 -> REQ_READY[0] 1 cycle, ADDER_START next cycle, RSP_VALID[0] with RSP_DATA=3.
2. REQ_VALID[1], op=1, M=13, A=4, B=9 -> ADDER_OPERATION=1, RSP_VALID[1], RSP_DATA=8, GRANT_ID=1.
3. All four REQ_VALID held high from reset -> grants 0,1,2,3,0,1 in order; each requester gets one RSP_VALID per round.
4. last_grant=1, REQ_VALID=4'b0101 -> grant 2 first, then 0; requester 0 is not serviced twice in a row.
5. Adder latency 10 cycles, ADDER_READY high during ISSUE -> ignored; ADDER_* operands stable through WAIT; RSP_VALID exactly 1 cycle after valid READY.
6. RST low during WAIT -> all outputs 0 immediately, no RSP_VALID. After release with REQ_VALID=4'b1010, requester 1 is granted first.

Source files
------------

// File: rtl/peripheral_dsa_pkg.sv
// peripheral_dsa_pkg: shared types and constants for the modular adder arbiter
package peripheral_dsa_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} arbiter_state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/peripheral_dsa_rr_arbiter.sv
// peripheral_dsa_rr_arbiter: combinational round-robin picker starting after last_grant
module peripheral_dsa_rr_arbiter
  import peripheral_dsa_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_WIDTH = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0]    req,
  input  logic [ID_WIDTH-1:0] last_grant,
  output logic [N_REQ-1:0]    grant,
  output logic [ID_WIDTH-1:0] grant_id,
  output logic                any_req
);
  // Scan farthest-first so the nearest requester after last_grant overwrites and wins
  always_comb begin
    any_req = |req;
    grant_id = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      automatic logic [ID_WIDTH-1:0] idx = ID_WIDTH'((int'(last_grant) + i) % N_REQ);
      if (req[idx]) grant_id = idx;
    end
    grant = '0;
    if (any_req) grant[grant_id] = 1'b1;
  end
endmodule

// File: rtl/peripheral_dsa_modular_adder_arbiter.sv
// peripheral_dsa_modular_adder_arbiter: round-robin sharing of one modular adder among N_REQ requesters
module peripheral_dsa_modular_adder_arbiter
  import peripheral_dsa_pkg::*;
#(
  parameter int DATA_SIZE = 64,
  parameter int N_REQ = 4,
  parameter int ID_WIDTH = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [N_REQ-1:0]           REQ_VALID,
  input  logic [N_REQ-1:0]           REQ_OPERATION,
  input  logic [N_REQ*DATA_SIZE-1:0] REQ_MODULO,
  input  logic [N_REQ*DATA_SIZE-1:0] REQ_DATA_A,
  input  logic [N_REQ*DATA_SIZE-1:0] REQ_DATA_B,
  output logic [N_REQ-1:0]           REQ_READY,
  output logic [N_REQ-1:0]           RSP_VALID,
  output logic [DATA_SIZE-1:0]       RSP_DATA,
  output logic                       ADDER_START,
  output logic                       ADDER_OPERATION,
  output logic [DATA_SIZE-1:0]       ADDER_MODULO,
  output logic [DATA_SIZE-1:0]       ADDER_DATA_A,
  output logic [DATA_SIZE-1:0]       ADDER_DATA_B,
  input  logic                       ADDER_READY,
  input  logic [DATA_SIZE-1:0]       ADDER_DATA_OUT,
  output logic                       BUSY,
  output logic [ID_WIDTH-1:0]        GRANT_ID
);
  arbiter_state_t state, state_n;
  logic [ID_WIDTH-1:0] last_grant, pick_id;
  logic [N_REQ-1:0] pick, rsp_sel;
  logic any_req;

  peripheral_dsa_rr_arbiter #(.N_REQ(N_REQ), .ID_WIDTH(ID_WIDTH)) u_rr (
    .req(REQ_VALID),
    .last_grant(last_grant),
    .grant(pick),
    .grant_id(pick_id),
    .any_req(any_req)
  );

  // Next state and the state-decoded handshake outputs; REQ_READY is masked while in reset
  always_comb begin
    state_n = state == IDLE ? (any_req ? ISSUE : IDLE) :
              state == ISSUE ? WAIT :
              state == WAIT ? (ADDER_READY ? RESPOND : WAIT) : IDLE;
    rsp_sel = '0;
    rsp_sel[GRANT_ID] = 1'b1;
    REQ_READY = (state == IDLE && RST) ? pick : '0;
    RSP_VALID = state == RESPOND ? rsp_sel : '0;
    ADDER_START = state == ISSUE;
    BUSY = state != IDLE;
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else state <= state_n;
  end

  // Operand capture at accept, result capture on adder completion, pointer update on respond
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ADDER_OPERATION <= 1'b0;
      ADDER_MODULO <= '0;
      ADDER_DATA_A <= '0;
      ADDER_DATA_B <= '0;
      GRANT_ID <= '0;
      RSP_DATA <= '0;
      last_grant <= ID_WIDTH'(N_REQ - 1);
    end else begin
      if (state == IDLE && any_req) begin
        ADDER_OPERATION <= REQ_OPERATION[pick_id];
        ADDER_MODULO <= REQ_MODULO[int'(pick_id)*DATA_SIZE +: DATA_SIZE];
        ADDER_DATA_A <= REQ_DATA_A[int'(pick_id)*DATA_SIZE +: DATA_SIZE];
        ADDER_DATA_B <= REQ_DATA_B[int'(pick_id)*DATA_SIZE +: DATA_SIZE];
        GRANT_ID <= pick_id;
      end
      if (state == WAIT && ADDER_READY) RSP_DATA <= ADDER_DATA_OUT;
      if (state == RESPOND) last_grant <= GRANT_ID;
    end
  end
endmodule
